// File: rtl/instr_queue_if.sv
// -----------------------------------------------------------------------------
// instr_queue_if
// Purpose : bundles the fetch-side enqueue port, the decode-side dequeue port,
//           the branch flush and the occupancy count of the instruction queue.
// Ports   : (interface signals)
//   enq_valid_F  fetch presents an instruction this cycle
//   enq_pc_F     PC of the presented instruction (64 bits)
//   enq_instr_F  instruction word at enq_pc_F (32 bits)
//   enq_ready_F  queue accepts an enqueue this cycle
//   deq_valid_D  head entry is valid for decode
//   deq_pc_D     PC of the head entry (64 bits)
//   deq_instr_D  instruction word of the head entry (32 bits)
//   deq_ready_D  decode consumes the head entry this cycle
//   flush        discard every queued entry (taken branch)
//   count        number of valid entries, 0..DEPTH (PTRW+1 bits)
// Modports: master = fetch/decode pipeline side, slave = the queue itself.
// -----------------------------------------------------------------------------
interface instr_queue_if #(
    parameter int PTRW = 2
);
    logic            enq_valid_F;
    logic [63:0]     enq_pc_F;
    logic [31:0]     enq_instr_F;
    logic            enq_ready_F;
    logic            deq_valid_D;
    logic [63:0]     deq_pc_D;
    logic [31:0]     deq_instr_D;
    logic            deq_ready_D;
    logic            flush;
    logic [PTRW:0]   count;

    modport master (
        output enq_valid_F, enq_pc_F, enq_instr_F, deq_ready_D, flush,
        input  enq_ready_F, deq_valid_D, deq_pc_D, deq_instr_D, count
    );

    modport slave (
        input  enq_valid_F, enq_pc_F, enq_instr_F, deq_ready_D, flush,
        output enq_ready_F, deq_valid_D, deq_pc_D, deq_instr_D, count
    );
endinterface

// File: rtl/instr_queue.sv
// -----------------------------------------------------------------------------
// instr_queue
// Purpose : small circular FIFO between the fetch and decode stages. Holds
//           {PC, instruction} pairs, strict FIFO order, no full- or
//           empty-bypass.
// Ports   :
//   clk    single clock, all state updates on posedge
//   reset  synchronous active-low reset
//   q      instr_queue_if.slave (enqueue, dequeue, flush, count)
// Parameters:
//   DEPTH  number of entries (2, 4 or 8)
//   PTRW   log2(DEPTH); pointers wrap naturally at this width
// Handshake: a transfer happens on a posedge where valid and ready are both
//   high and flush is low. enq_ready_F depends only on count (count < DEPTH),
//   deq_valid_D only on count (count != 0); neither looks at the other side,
//   so a full queue refuses an enqueue even while a dequeue happens.
// -----------------------------------------------------------------------------
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int PTRW  = 2
) (
    input  logic              clk,
    input  logic              reset,
    instr_queue_if.slave      q
);
    localparam logic [PTRW:0] FULL_COUNT = (PTRW + 1)'(DEPTH);

    logic [63:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [PTRW-1:0] head;
    logic [PTRW-1:0] tail;
    logic [PTRW:0]   cnt;

    logic enq_fire;
    logic deq_fire;

    assign q.enq_ready_F = (cnt < FULL_COUNT);
    assign q.deq_valid_D = (cnt != '0);
    // Head data is forced to zero when empty so stale storage never leaks out.
    assign q.deq_pc_D    = q.deq_valid_D ? pc_mem[head]    : 64'd0;
    assign q.deq_instr_D = q.deq_valid_D ? instr_mem[head] : 32'd0;
    assign q.count       = cnt;

    assign enq_fire = q.enq_valid_F && q.enq_ready_F && !q.flush;
    assign deq_fire = q.deq_valid_D && q.deq_ready_D && !q.flush;

    always_ff @(posedge clk) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            cnt       <= '0;
            pc_mem    <= '{default: 64'd0};
            instr_mem <= '{default: 32'd0};
        end else if (q.flush) begin
            // Storage is left as is; deq_valid_D=0 hides it.
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (enq_fire) begin
                pc_mem[tail]    <= q.enq_pc_F;
                instr_mem[tail] <= q.enq_instr_F;
                tail            <= tail + 1'b1;
            end
            if (deq_fire) begin
                head <= head + 1'b1;
            end
            case ({enq_fire, deq_fire})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_queue
// Directed bench for instr_queue (DEPTH=4). Inputs change 1 ns after each
// posedge; outputs are checked at the same point, i.e. away from the edge.
// -----------------------------------------------------------------------------
module tb_instr_queue;
    logic clk;
    logic reset;

    int tests_run;
    int tests_failed;

    instr_queue_if #(.PTRW(2)) q_if ();

    instr_queue #(.DEPTH(4), .PTRW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q_if)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ev, input logic [63:0] pc,
                         input logic dr, input logic fl);
        q_if.enq_valid_F = ev;
        q_if.enq_pc_F    = pc;
        q_if.enq_instr_F = 32'hAAAA_0000 + pc[31:0];
        q_if.deq_ready_D = dr;
        q_if.flush       = fl;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [63:0] pc;
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        drive(1'b1, 64'd64, 1'b1, 1'b0);

        // Reset low for 5 cycles; enqueue attempts are ignored meanwhile.
        repeat (5) tick();
        chk("rst_count", 64'(q_if.count), 64'd0);
        chk("rst_deq_valid", 64'(q_if.deq_valid_D), 64'd0);
        reset = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        chk("post_rst_count", 64'(q_if.count), 64'd0);
        chk("post_rst_deq_valid", 64'(q_if.deq_valid_D), 64'd0);
        chk("post_rst_deq_pc", q_if.deq_pc_D, 64'd0);
        chk("post_rst_deq_instr", 64'(q_if.deq_instr_D), 64'd0);
        chk("post_rst_enq_ready", 64'(q_if.enq_ready_F), 64'd1);

        // Fill: PCs 0,4,8,12; head stays on PC 0.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 64'(4 * i), 1'b0, 1'b0);
            tick();
            chk("fill_count", 64'(q_if.count), 64'(i + 1));
            chk("fill_head_pc", q_if.deq_pc_D, 64'd0);
            chk("fill_head_instr", 64'(q_if.deq_instr_D), 64'hAAAA_0000);
        end
        chk("full_enq_ready", 64'(q_if.enq_ready_F), 64'd0);
        chk("full_deq_valid", 64'(q_if.deq_valid_D), 64'd1);

        // Fifth enqueue refused while full.
        drive(1'b1, 64'd16, 1'b0, 1'b0);
        tick();
        chk("refused_count", 64'(q_if.count), 64'd4);
        chk("refused_head_pc", q_if.deq_pc_D, 64'd0);

        // Drain; first step also offers an enqueue, refused because full.
        for (int i = 0; i < 4; i++) begin
            drive(i == 0, 64'd16, 1'b1, 1'b0);
            chk("drain_head_pc", q_if.deq_pc_D, 64'(4 * i));
            chk("drain_head_instr", 64'(q_if.deq_instr_D), 64'(32'hAAAA_0000 + 32'(4 * i)));
            tick();
            chk("drain_count", 64'(q_if.count), 64'(3 - i));
        end
        chk("drained_deq_valid", 64'(q_if.deq_valid_D), 64'd0);
        chk("drained_deq_pc", q_if.deq_pc_D, 64'd0);
        chk("drained_enq_ready", 64'(q_if.enq_ready_F), 64'd1);

        // Streaming: first cycle is enqueue-only (empty, no bypass), then
        // every cycle dequeues the previous PC and enqueues PC+4.
        pc = 64'd256;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, pc, 1'b1, 1'b0);
            tick();
            chk("stream_count", 64'(q_if.count), 64'd1);
            chk("stream_head_pc", q_if.deq_pc_D, pc);
            pc = pc + 64'd4;
        end
        drive(1'b0, 64'd0, 1'b1, 1'b0);
        tick();
        chk("stream_end_count", 64'(q_if.count), 64'd0);
        chk("stream_end_deq_valid", 64'(q_if.deq_valid_D), 64'd0);

        // Flush with 3 entries and a concurrent enqueue/dequeue.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'(4096 + 4 * i), 1'b0, 1'b0);
            tick();
        end
        chk("preflush_count", 64'(q_if.count), 64'd3);
        chk("preflush_head_pc", q_if.deq_pc_D, 64'd4096);
        drive(1'b1, 64'd4004, 1'b1, 1'b1);
        tick();
        chk("flush_count", 64'(q_if.count), 64'd0);
        chk("flush_deq_valid", 64'(q_if.deq_valid_D), 64'd0);
        chk("flush_deq_pc", q_if.deq_pc_D, 64'd0);
        drive(1'b1, 64'd4004, 1'b0, 1'b0);
        tick();
        chk("postflush_count", 64'(q_if.count), 64'd1);
        chk("postflush_head_pc", q_if.deq_pc_D, 64'd4004);
        chk("postflush_head_instr", 64'(q_if.deq_instr_D), 64'(32'hAAAA_0000 + 32'd4004));

        // Second entry, then reset mid-operation with enqueue and dequeue.
        drive(1'b1, 64'd4008, 1'b0, 1'b0);
        tick();
        chk("prerst_count", 64'(q_if.count), 64'd2);
        reset = 1'b0;
        drive(1'b1, 64'd4012, 1'b1, 1'b0);
        tick();
        chk("midrst_count", 64'(q_if.count), 64'd0);
        chk("midrst_deq_valid", 64'(q_if.deq_valid_D), 64'd0);
        chk("midrst_deq_pc", q_if.deq_pc_D, 64'd0);
        reset = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        tick();
        chk("afterrst_count", 64'(q_if.count), 64'd0);
        chk("afterrst_enq_ready", 64'(q_if.enq_ready_F), 64'd1);

        // Reset wins over flush and enqueue; next enqueue lands at the head.
        reset = 1'b0;
        drive(1'b1, 64'd8000, 1'b0, 1'b1);
        tick();
        reset = 1'b1;
        drive(1'b1, 64'd8000, 1'b0, 1'b0);
        tick();
        chk("rst_flush_then_enq_count", 64'(q_if.count), 64'd1);
        chk("rst_flush_then_enq_pc", q_if.deq_pc_D, 64'd8000);

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
